fp32_mul_dispatcher: RTL

Operand-side front end for the 32-bit IEEE 754 multiplier. It buffers incoming operand pairs in a small FIFO and issues them one at a time to the multiplier's start/done handshake. It holds operands stable for the whole operation and captures the multiplier's transient status flags. Each result is returned on a valid/ready output port together with its flags, in issue order.

---
 rtl/fp32_pkg.sv | 28 ++
 rtl/fp32_operand_fifo.sv | 44 ++++
 rtl/fp32_mul_dispatcher.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared types and constants for the fp32 multiplier dispatcher.
package fp32_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } disp_state_e;

    // Bit positions within out_flags = {timeout, unf, ovf, inf, nan}
    localparam int unsigned FlagNan     = 0;
    localparam int unsigned FlagInf     = 1;
    localparam int unsigned FlagOvf     = 2;
    localparam int unsigned FlagUnf     = 3;
    localparam int unsigned FlagTimeout = 4;
    localparam int unsigned NumStatus   = 4;
    localparam int unsigned NumFlags    = 5;

    localparam logic [7:0]  NanExp  = 8'hFF;
    localparam logic [30:0] SatMag  = 31'h7FFFFFFF;
    localparam int unsigned ExpBias = 127;

    function automatic logic [31:0] sat_product(input logic [31:0] a, input logic [31:0] b);
        return {a[31] ^ b[31], SatMag};
    endfunction

endpackage

// File: rtl/fp32_operand_fifo.sv
// Synchronous operand-pair FIFO; wrap bit on each pointer separates full from empty.
module fp32_operand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fp32_mul_dispatcher.sv
// Buffers operand pairs and issues them one at a time to the fp32 multiplier.
// Optional watchdog on a missing done pulse: define FP32_DISP_WATCHDOG_EN.
module fp32_mul_dispatcher
    import fp32_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_product_i,
    input  logic        mul_done_i,
    input  logic        mul_nan_i,
    input  logic        mul_inf_i,
    input  logic        mul_ovf_i,
    input  logic        mul_unf_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic [4:0]  out_flags
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    disp_state_e          state_q, state_d;
    logic [31:0]          op_a_q, op_b_q, prod_q;
    logic [NumStatus-1:0] sticky_q, flag_in, flags_now;
    logic [NumFlags-1:0]  flags_q;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [63:0]          fifo_head;
    logic                 timeout;

    fp32_operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign fifo_push   = in_valid && in_ready;
    assign mul_start_o = (state_q == StIssue);
    assign out_valid   = (state_q == StResp);
    assign mul_a_o     = op_a_q;
    assign mul_b_o     = op_b_q;
    assign out_product = prod_q;
    assign out_flags   = flags_q;

    always_comb begin
        flag_in          = '0;
        flag_in[FlagNan] = mul_nan_i;
        flag_in[FlagInf] = mul_inf_i;
        flag_in[FlagOvf] = mul_ovf_i;
        flag_in[FlagUnf] = mul_unf_i;
    end

    // Flags that pulse in the done cycle itself must still reach the result
    assign flags_now = sticky_q | flag_in;

`ifdef FP32_DISP_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] wd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else if (state_q == StIssue) begin
            wd_cnt_q <= '0;
        end else if (state_q == StWait) begin
            wd_cnt_q <= wd_cnt_q + CntW'(1);
        end
    end

    assign timeout = (state_q == StWait) && !mul_done_i &&
                     (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (mul_done_i || timeout) state_d = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            sticky_q <= '0;
        end else if (fifo_pop) begin
            op_a_q   <= fifo_head[63:32];
            op_b_q   <= fifo_head[31:0];
            sticky_q <= '0;
        end else if (state_q == StWait) begin
            sticky_q <= flags_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            flags_q <= '0;
        end else if (state_q == StWait) begin
            if (mul_done_i) begin
                prod_q  <= mul_product_i;
                flags_q <= {1'b0, flags_now};
            end else if (timeout) begin
                prod_q  <= sat_product(op_a_q, op_b_q);
                flags_q <= {1'b1, flags_now};
            end
        end
    end

endmodule
